// File: rtl/park_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | park_pkg : shared state type, default parameters and counter-width helper |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package park_pkg;

  typedef enum logic [0:0] {
    READY  = 1'b0,
    LOCKED = 1'b1
  } park_state_e;

  localparam int         DEF_WIDTH       = 3;
  localparam int         DEF_NUM_PARKS   = 6;
  localparam logic [2:0] DEF_TAPS        = 3'b110;
  localparam int         DEF_MAX_FAIL    = 3;
  localparam int         DEF_LOCK_CYCLES = 4;

  // Bits needed to hold values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/park_pattern_lfsr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | park_pattern_lfsr : key pattern register with load and optional LFSR step |
// | Stepping is built only when DECRYPT_ROLLING_EN is defined. Revision 1.0   |
// +--------------------------------------------------------------------------+
module park_pattern_lfsr
  import park_pkg::*;
#(
  parameter int               WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  output logic [WIDTH-1:0] pattern
);

  logic [WIDTH-1:0] pattern_q;
  logic [WIDTH-1:0] pattern_d;

`ifdef DECRYPT_ROLLING_EN
  logic [WIDTH-1:0] next_pattern;
  assign next_pattern = {pattern_q[WIDTH-2:0], ^(pattern_q & TAPS)};
`else
  logic unused_step;
  assign unused_step = step ^ (^TAPS);
`endif

  // A load always beats a step, so a simultaneous accept never rolls.
  always_comb begin
    pattern_d = pattern_q;
    if (load) begin
      pattern_d = load_val;
    end
`ifdef DECRYPT_ROLLING_EN
    else if (step) begin
      pattern_d = next_pattern;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_q <= '0;
    end else begin
      pattern_q <= pattern_d;
    end
  end

  assign pattern = pattern_q;

endmodule
`default_nettype wire

// File: rtl/park_token_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | park_token_decoder : XOR token decode, range check, lockout after repeated|
// | invalid tokens. Rolling key via DECRYPT_ROLLING_EN. Revision 1.0          |
// +--------------------------------------------------------------------------+
module park_token_decoder
  import park_pkg::*;
#(
  parameter int               WIDTH       = DEF_WIDTH,
  parameter int               NUM_PARKS   = DEF_NUM_PARKS,
  parameter logic [WIDTH-1:0] TAPS        = WIDTH'(DEF_TAPS),
  parameter int               MAX_FAIL    = DEF_MAX_FAIL,
  parameter int               LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_load,
  input  logic [WIDTH-1:0] key_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_token,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_park,
  output logic             out_ok,
  output logic             locked
);

  localparam int             FW         = cnt_width(MAX_FAIL);
  localparam int             LW         = cnt_width(LOCK_CYCLES);
  localparam logic [WIDTH:0] PARK_LIMIT = (WIDTH+1)'(NUM_PARKS);
  localparam logic [FW-1:0]  FAIL_LIMIT = FW'(MAX_FAIL);
  localparam logic [LW-1:0]  LOCK_LOAD  = LW'(LOCK_CYCLES);

  park_state_e      state_q,     state_d;
  logic [FW-1:0]    fail_cnt_q,  fail_cnt_d;
  logic [LW-1:0]    lock_cnt_q,  lock_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic             out_ok_q,    out_ok_d;
  logic [WIDTH-1:0] out_park_q,  out_park_d;

  logic [WIDTH-1:0] pattern;
  logic [WIDTH-1:0] decoded;
  logic             decoded_ok;
  logic             accept;

  assign in_ready   = (state_q == READY) && (!out_valid_q || out_ready);
  assign accept     = in_valid && in_ready;
  assign decoded    = in_token ^ pattern;
  // Widened compare keeps NUM_PARKS == 2**WIDTH always in range.
  assign decoded_ok = {1'b0, decoded} < PARK_LIMIT;

  park_pattern_lfsr #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_pattern (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (key_load),
    .load_val (key_in),
    .step     (accept && !key_load),
    .pattern  (pattern)
  );

  always_comb begin
    state_d     = state_q;
    fail_cnt_d  = fail_cnt_q;
    lock_cnt_d  = lock_cnt_q;
    out_valid_d = out_valid_q;
    out_ok_d    = out_ok_q;
    out_park_d  = out_park_q;

    if (accept) begin
      out_park_d  = decoded;
      out_ok_d    = decoded_ok;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      READY: begin
        if (accept) begin
          if (decoded_ok) begin
            fail_cnt_d = '0;
          end else if (fail_cnt_q == FAIL_LIMIT - 1'b1) begin
            state_d    = LOCKED;
            lock_cnt_d = LOCK_LOAD;
            fail_cnt_d = '0;
          end else begin
            fail_cnt_d = fail_cnt_q + 1'b1;
          end
        end
      end
      LOCKED: begin
        lock_cnt_d = lock_cnt_q - 1'b1;
        if (lock_cnt_q == LW'(1)) begin
          state_d = READY;
        end
      end
      default: state_d = READY;
    endcase

    // Administrative override releases any lockout and forgets past failures.
    if (key_load) begin
      state_d    = READY;
      fail_cnt_d = '0;
      lock_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= READY;
      fail_cnt_q  <= '0;
      lock_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_ok_q    <= 1'b0;
      out_park_q  <= '0;
    end else begin
      state_q     <= state_d;
      fail_cnt_q  <= fail_cnt_d;
      lock_cnt_q  <= lock_cnt_d;
      out_valid_q <= out_valid_d;
      out_ok_q    <= out_ok_d;
      out_park_q  <= out_park_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ok    = out_ok_q;
  assign out_park  = out_park_q;
  assign locked    = (state_q == LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_park_token_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// Scoreboard bench for park_token_decoder: directed scenarios plus random traffic
// checked against a behavioural model of decode, range check and lockout rules.
module tb_park_token_decoder;

  localparam int         NP = 6;
  localparam int         MF = 3;
  localparam int         LC = 4;
  localparam logic [2:0] TP = 3'b110;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_load = 1'b0;
  logic [2:0] key_in = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_token = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] out_park;
  logic       out_ok;
  logic       locked;

  park_token_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_load  (key_load),
    .key_in    (key_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_token  (in_token),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_park  (out_park),
    .out_ok    (out_ok),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] park;
    logic       ok;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  // Reference model: current key, failures so far, lockout cycles remaining, result pending.
  int   m_pat = 0;
  int   m_fail = 0;
  int   m_lock = 0;
  bit   m_ov = 1'b0;
  bit   cur_ov = 1'b0;
  bit   mon_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int roll(input int p);
    int fb;
    fb = $countones(p & int'(TP)) % 2;
    return ((p * 2) + fb) % 8;
  endfunction

  // One clock of stimulus; the model advances by the same edge.
  task automatic cycle(input bit kl, input logic [2:0] ki, input bit iv,
                       input logic [2:0] tok, input bit ordy);
    bit   exp_ready;
    bit   acc;
    int   park;
    bit   ok;
    exp_t e;
    @(negedge clk);
    key_load  = kl;
    key_in    = ki;
    in_valid  = iv;
    in_token  = tok;
    out_ready = ordy;
    #1;
    exp_ready = (m_lock == 0) && (!m_ov || ordy);
    check("in_ready", in_ready, exp_ready);
    check("locked", locked, m_lock > 0);
    cur_ov = m_ov;
    mon_en = 1'b1;
    acc = iv && exp_ready;
    park = (int'(tok) ^ m_pat) % 8;
    ok = park < NP;
    if (acc) begin
      e.park = 3'(park);
      e.ok   = ok;
      q.push_back(e);
      m_ov = 1'b1;
    end else if (ordy) begin
      m_ov = 1'b0;
    end
    if (kl) begin
      m_pat  = int'(ki);
      m_fail = 0;
      m_lock = 0;
    end else begin
      if (m_lock > 0) m_lock--;
`ifdef DECRYPT_ROLLING_EN
      if (acc) m_pat = roll(m_pat);
`endif
      if (acc) begin
        if (ok) begin
          m_fail = 0;
        end else begin
          m_fail++;
          if (m_fail == MF) begin
            m_fail = 0;
            m_lock = LC;
          end
        end
      end
    end
  endtask

  // Monitor: compares the presented result with the scoreboard head, pops on handshake.
  initial begin : monitor
    exp_t d;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && mon_en) begin
        check("out_valid", out_valid, cur_ov);
        if (out_valid === 1'b1) begin
          if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_underflow: got out_valid=1 expected no pending result at %0t", $time);
          end else begin
            check("out_park", out_park, q[0].park);
            check("out_ok", out_ok, q[0].ok);
            if (out_ready) d = q.pop_front();
          end
        end
      end
    end
  end

  task automatic reset_mid();
    mon_en = 1'b0;
    @(negedge clk);
    #1;
    check("pre_rst_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_out_park", out_park, 0);
    check("rst_out_ok", out_ok, 0);
    q.delete();
    m_pat = 0; m_fail = 0; m_lock = 0; m_ov = 1'b0;
    in_valid = 1'b0; key_load = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++) begin
      cycle($urandom_range(0, 31) == 0, 3'($urandom_range(0, 7)),
            $urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)),
            $urandom_range(0, 9) < 7);
    end
  endtask

  initial begin : stimulus
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_park", out_park, 0);
    check("reset_out_ok", out_ok, 0);
    check("reset_locked", locked, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Key 101, token 001 -> park 4; second token exercises static vs rolling key.
    cycle(1, 3'b101, 0, 3'b000, 1);
    cycle(0, 3'b000, 1, 3'b001, 1);
    @(posedge clk); #1;
    check("first_park", out_park, 3'd4);
    check("first_ok", out_ok, 1);
    cycle(0, 3'b000, 1, 3'b010, 1);
    cycle(0, 3'b000, 0, 3'b000, 1);

    // Backpressure: result held five cycles, then released with a new token.
    cycle(0, 3'b000, 1, 3'b011, 0);
    for (int i = 0; i < 5; i++) cycle(0, 3'b000, 1, 3'($urandom_range(0, 7)), 0);
    cycle(0, 3'b000, 1, 3'b100, 1);
    cycle(0, 3'b000, 0, 3'b000, 1);

    // Lockout: three tokens decoding to park 6, then blocked input throughout the window.
    cycle(1, 3'b101, 0, 3'b000, 1);
    for (int i = 0; i < 3; i++) cycle(0, 3'b000, 1, 3'(6 ^ m_pat), 1);
    for (int i = 0; i < LC + 2; i++) cycle(0, 3'b000, 1, 3'(6 ^ m_pat), 1);
    cycle(0, 3'b000, 1, 3'(1 ^ m_pat), 1);

    // Override during lockout, then key_load simultaneous with an accept.
    cycle(1, 3'b101, 0, 3'b000, 1);
    for (int i = 0; i < 3; i++) cycle(0, 3'b000, 1, 3'(6 ^ m_pat), 1);
    cycle(0, 3'b000, 0, 3'b000, 1);
    cycle(1, 3'b010, 0, 3'b000, 1);
    cycle(1, 3'b111, 1, 3'b001, 1);
    @(posedge clk); #1;
    check("simul_park", out_park, 3'b011);
    cycle(0, 3'b000, 1, 3'b000, 1);
    @(posedge clk); #1;
    check("no_roll_park", out_park, 3'b111);

    random_run(3000);

    // Async reset with a held result, then pattern must be zero again.
    cycle(0, 3'b000, 0, 3'b000, 1);
    cycle(0, 3'b000, 1, 3'b001, 0);
    reset_mid();
    cycle(0, 3'b000, 1, 3'b011, 1);
    @(posedge clk); #1;
    check("post_rst_park", out_park, 3'b011);

    random_run(1000);

    for (int i = 0; i < 3; i++) cycle(0, 3'b000, 0, 3'b000, 1);
    mon_en = 1'b0;
    check("sb_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/park_token_decoder.md
# park_token_decoder

Streaming parking-token decoder: XORs each incoming token with a key pattern to recover a park number, range-checks it, and returns it through a registered valid/ready output. A rolling-key mode advances the pattern after every accepted token, and a lockout state blocks input after repeated invalid tokens. Sits between the token entry front-end and the park allocation logic. It is the parametrised, sequential successor to the 3-bit combinational decryptor.

## Interface
Parameters:
- WIDTH, 3, token/pattern/park width in bits (≥2)
- NUM_PARKS, 6, valid park numbers are 0..NUM_PARKS-1 (≤2^WIDTH)
- TAPS, 3'b110, LFSR feedback mask (WIDTH bits)
- MAX_FAIL, 3, consecutive invalid tokens that trigger lockout (≥1)
- LOCK_CYCLES, 4, lockout duration in cycles (≥1)

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- key_load  in  1  load key_in into pattern
- key_in  in  WIDTH  new key pattern
- in_valid  in  1  token offered
- in_ready  out  1  token accepted when in_valid&&in_ready
- in_token  in  WIDTH  encrypted token
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts result
- out_park  out  WIDTH  token ^ pattern
- out_ok  out  1  out_park < NUM_PARKS
- locked  out  1  high while in LOCKED state

## Operation
- States: READY, LOCKED. Reset enters READY.
- in_ready = (state==READY) && (!out_valid || out_ready).
- On accept: out_park <= in_token ^ pattern; out_ok <= (in_token ^ pattern) < NUM_PARKS; out_valid <= 1.
- out_valid clears on out_ready without a new accept. Output stays stable while out_valid && !out_ready.
- The fail counter increments on an accepted invalid token and clears on an accepted valid token.
- When an accept brings the fail count to MAX_FAIL, the next state is LOCKED. The lock counter loads LOCK_CYCLES and the fail count clears. The failing result is still presented on the output.
- In LOCKED, the lock counter decrements every cycle. On reaching 0, the block returns to READY.
- key_load in any state: pattern <= key_in, fail count cleared, state forced to READY (administrative override).
- key_load and accept in the same cycle: the token is decoded with the old pattern. key_load wins the pattern update, so no roll occurs.
- Zero pattern is legal. Rolling keeps a zero pattern at zero.
- If NUM_PARKS == 2^WIDTH, out_ok is constant 1 and lockout is unreachable.

## Timing
- Reset values: pattern=0, out_valid=0, out_park=0, out_ok=0, locked=0, fail count=0, lock count=0. in_ready=1 one cycle after rst_n deasserts.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 token per cycle while out_ready=1.
- locked rises in the cycle after the MAX_FAIL-th invalid accept and stays high exactly LOCK_CYCLES cycles. in_ready is 0 for that whole window.
- Reset asserted mid-operation clears all state immediately and discards any pending output.

## Configuration
- DECRYPT_ROLLING_EN defined: on every accept without key_load, pattern <= {pattern[WIDTH-2:0], ^(pattern & TAPS)}.
- DECRYPT_ROLLING_EN undefined: pattern changes only on key_load. The LFSR logic is not instantiated.

## Structure
- Package park_pkg holds: the state enum typedef (READY, LOCKED), default WIDTH/NUM_PARKS/TAPS/MAX_FAIL/LOCK_CYCLES constants, and a clog2-based counter-width function.
- One sub-module, park_pattern_lfsr. It holds the pattern register, load and step logic, and is conditionally stepped under DECRYPT_ROLLING_EN.
- Counters and the FSM live in the top level.

## Test plan
All scenarios use default parameters.
- Static key (macro off): key 3'b101, token 3'b001 → next cycle out_park=3'b100, out_ok=1. Pattern remains 3'b101.
- Rolling key (macro on): key 3'b101, token 3'b001 → park 4, pattern becomes 3'b011. Then token 3'b010 → park 3'b001, out_ok=1.
- Backpressure: out_ready=0 with out_valid=1 → in_ready=0, out_park held for 5 cycles. Release out_ready → the next token is accepted in the same cycle.
- Lockout (macro off): key 3'b101, token 3'b011 three times → out_park=6, out_ok=0 each time. locked is high for 4 cycles, in_ready=0 throughout, and the fail count is 0 on exit.
- Override and simultaneity: key_load 3'b010 during LOCKED → locked=0 next cycle. key_load 3'b111 together with token 3'b001 (pattern 3'b010) → out_park=3'b011, pattern=3'b111, no roll.
- Async reset mid-stream: rst_n low with out_valid=1 → out_valid=0 and locked=0 immediately; pattern reads 0 after release.
